line_window_3x3: RTL and testbench

Streaming 3x3 window generator placed directly upstream of the convolution stage. It accepts one signed pixel per handshake in raster order and keeps the two previous image rows in circular line buffers. For every position where a full 3x3 neighbourhood exists (valid-only, no padding), it presents the nine window pixels in parallel as `a0_out..a8_out`, which map one-to-one onto the convolution stage's `a0_in..a8_in`. Valid/ready backpressure stalls the input while the downstream multiply-accumulate is busy.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/line_window_3x3_line_ram.sv | 23 ++
 rtl/line_window_3x3.sv | 118 +++++++++++
 tb/tb_line_window_3x3.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: pixel width and the 3x3 tap ordering.
package cnn_pkg;

  localparam int unsigned PIX_WIDTH = 9;
  localparam int unsigned WIN_TAPS  = 9;
  localparam int unsigned WIN_DIM   = 3;

  // Row-major tap indices: A0..A2 oldest row, A6..A8 newest row, A8 newest pixel.
  localparam int unsigned A0 = 0;
  localparam int unsigned A1 = 1;
  localparam int unsigned A2 = 2;
  localparam int unsigned A3 = 3;
  localparam int unsigned A4 = 4;
  localparam int unsigned A5 = 5;
  localparam int unsigned A6 = 6;
  localparam int unsigned A7 = 7;
  localparam int unsigned A8 = 8;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/line_window_3x3_line_ram.sv
// One image-row circular buffer; asynchronous read so the old entry is seen on the write edge.
module line_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 28,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Storage write; no reset so the array maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator: two line buffers, a shift window and a one-deep output register.
module line_window_3x3
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_WIDTH,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIDTH-1:0] a0_out,
  output logic [WIDTH-1:0] a1_out,
  output logic [WIDTH-1:0] a2_out,
  output logic [WIDTH-1:0] a3_out,
  output logic [WIDTH-1:0] a4_out,
  output logic [WIDTH-1:0] a5_out,
  output logic [WIDTH-1:0] a6_out,
  output logic [WIDTH-1:0] a7_out,
  output logic [WIDTH-1:0] a8_out,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             pix_acc;
  logic             emit;
  logic [WIDTH-1:0] t1, t2;
  logic [WIDTH-1:0] win_q   [WIN_TAPS];
  logic [WIDTH-1:0] nxt_win [WIN_TAPS];
  logic [WIDTH-1:0] a_q     [WIN_TAPS];

  assign pix_ready = !win_valid || win_ready;
  assign pix_acc   = pix_valid && pix_ready;
  assign emit      = (row >= RW'(2)) && (col >= CW'(2));

  line_ram #(.WIDTH(WIDTH), .DEPTH(IMG_W), .AW(CW)) lb1 (
    .clk     (clk),
    .we      (pix_acc),
    .addr    (col),
    .wr_data (pix_in),
    .rd_data (t1)
  );

  line_ram #(.WIDTH(WIDTH), .DEPTH(IMG_W), .AW(CW)) lb2 (
    .clk     (clk),
    .we      (pix_acc),
    .addr    (col),
    .wr_data (t1),
    .rd_data (t2)
  );

  // Post-shift window: every row moves one column left, new right column is {t2, t1, pix_in}.
  always_comb begin
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      nxt_win[win_idx(r, 0)] = win_q[win_idx(r, 1)];
      nxt_win[win_idx(r, 1)] = win_q[win_idx(r, 2)];
    end
    nxt_win[A2] = t2;
    nxt_win[A5] = t1;
    nxt_win[A8] = pix_in;
  end

  // Shift window register; deliberately unreset, stale content is never emitted after reset.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      for (int unsigned i = 0; i < WIN_TAPS; i++) win_q[i] <= nxt_win[i];
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_acc) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Output register: load on qualifying accept, otherwise drop valid once taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int unsigned i = 0; i < WIN_TAPS; i++) a_q[i] <= '0;
    end else if (pix_acc && emit) begin
      win_valid <= 1'b1;
      win_last  <= (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
      for (int unsigned i = 0; i < WIN_TAPS; i++) a_q[i] <= nxt_win[i];
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  assign a0_out = a_q[A0];
  assign a1_out = a_q[A1];
  assign a2_out = a_q[A2];
  assign a3_out = a_q[A3];
  assign a4_out = a_q[A4];
  assign a5_out = a_q[A5];
  assign a6_out = a_q[A6];
  assign a7_out = a_q[A7];
  assign a8_out = a_q[A8];

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 on a 4x4 image with a 2D-image reference model.
module tb_line_window_3x3;

  localparam int WIDTH = 9;
  localparam int W     = 4;
  localparam int H     = 4;

  typedef struct packed {
    logic [9*WIDTH-1:0] px;
    logic               last;
  } win_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [WIDTH-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic             win_valid;
  logic             win_ready;
  logic             win_last;

  line_window_3x3 #(.WIDTH(WIDTH), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .a0_out    (a0),
    .a1_out    (a1),
    .a2_out    (a2),
    .a3_out    (a3),
    .a4_out    (a4),
    .a5_out    (a5),
    .a6_out    (a6),
    .a7_out    (a7),
    .a8_out    (a8),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the current frame as an image; a window is the 3x3 block ending at (row, col).
  logic [WIDTH-1:0] img [H][W];
  int   m_col = 0;
  int   m_row = 0;
  win_t sb [$];
  win_t got_q [$];
  int   win_seen   = 0;
  int   stall_seen = 0;

  int gap_pct   = 0;
  int drop_pct  = 0;
  bit stall_arm = 0;
  int stall_cnt = 0;

  win_t held;
  bit   held_ok = 0;

  function automatic win_t dut_win();
    win_t w;
    w.px   = {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    w.last = win_last;
    return w;
  endfunction

  function automatic win_t mkwin(input int v [9], input logic last);
    win_t w;
    for (int i = 0; i < 9; i++) w.px[i*WIDTH +: WIDTH] = WIDTH'(v[i]);
    w.last = last;
    return w;
  endfunction

  task automatic model_accept(input logic [WIDTH-1:0] p);
    win_t e;
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          e.px[(rr*3+cc)*WIDTH +: WIDTH] = img[m_row-2+rr][m_col-2+cc];
      e.last = (m_row == H-1) && (m_col == W-1);
      sb.push_back(e);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end
  endtask

  // Monitor: handshake consistency, reset values, hold stability and scoreboard pop on accept.
  always @(negedge clk) begin
    win_t a;
    a = dut_win();
    if (!rst_n) begin
      checks++;
      if (win_valid !== 1'b0 || win_last !== 1'b0 || a.px !== '0 || pix_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state valid=%b last=%b px=%h ready=%b want 0 0 0 1",
                 win_valid, win_last, a.px, pix_ready);
      end
      held_ok = 0;
    end else begin
      checks++;
      if (pix_ready !== (!win_valid || win_ready)) begin
        errors++;
        $display("FAIL pix_ready got=%b want=%b", pix_ready, !win_valid || win_ready);
      end
      if (!pix_ready) stall_seen++;
      if (win_valid && !win_ready) begin
        if (held_ok) begin
          checks++;
          if (a !== held) begin
            errors++;
            $display("FAIL hold_stable got=%h want=%h", a, held);
          end
        end
        held    = a;
        held_ok = 1;
      end else begin
        held_ok = 0;
      end
      if (win_valid && win_ready) begin
        checks++;
        win_seen++;
        got_q.push_back(a);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window got=%h want=none", a);
        end else begin
          win_t e;
          e = sb.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL window got=%h want=%h", a, e);
          end
        end
      end
    end
  end

  // Downstream ready: optional one-shot 5-cycle stall after a window appears, else random drops.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        win_ready = 1'b0;
        stall_cnt--;
      end else if (stall_arm && win_valid) begin
        win_ready = 1'b0;
        stall_cnt = 4;
        stall_arm = 0;
      end else begin
        win_ready = ($urandom_range(0, 99) >= drop_pct);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] p);
    bit acc = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b1;
    pix_in    = p;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (pix_ready) begin
        model_accept(p);
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL pixel_timeout got=not_accepted want=accepted pix=%h", p);
    end
  endtask

  task automatic send_range(input int first, input int n);
    for (int i = 0; i < n; i++) send(WIDTH'(first + i));
  endtask

  task automatic drain_and_count(input string name, input int n);
    int t = 0;
    while ((sb.size() != 0 || win_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (sb.size() != 0 || win_seen != n) begin
      errors++;
      $display("FAIL %s windows got=%0d pending=%0d want=%0d pending=0", name, win_seen, sb.size(), n);
    end
  endtask

  task automatic check_got(input string name, input int idx, input win_t e);
    checks++;
    if (idx >= got_q.size()) begin
      errors++;
      $display("FAIL %s missing got=%0d_windows want_index=%0d", name, got_q.size(), idx);
    end else if (got_q[idx] !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got_q[idx], e);
    end
  endtask

  task automatic new_test();
    win_seen   = 0;
    stall_seen = 0;
    got_q.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain stream, always ready.
    new_test();
    send_range(1, 16);
    drain_and_count("basic", 4);
    check_got("basic_w0", 0, mkwin('{1, 2, 3, 5, 6, 7, 9, 10, 11}, 1'b0));
    check_got("basic_w1", 1, mkwin('{2, 3, 4, 6, 7, 8, 10, 11, 12}, 1'b0));
    check_got("basic_w2", 2, mkwin('{5, 6, 7, 9, 10, 11, 13, 14, 15}, 1'b0));
    check_got("basic_w3", 3, mkwin('{6, 7, 8, 10, 11, 12, 14, 15, 16}, 1'b1));

    // Downstream stall after the first window.
    new_test();
    stall_arm = 1;
    send_range(1, 16);
    drain_and_count("stall", 4);
    check_got("stall_w0", 0, mkwin('{1, 2, 3, 5, 6, 7, 9, 10, 11}, 1'b0));
    check_got("stall_w3", 3, mkwin('{6, 7, 8, 10, 11, 12, 14, 15, 16}, 1'b1));
    checks++;
    if (stall_seen < 5) begin
      errors++;
      $display("FAIL stall_backpressure got=%0d_cycles want>=5", stall_seen);
    end

    // Input gaps.
    new_test();
    gap_pct = 50;
    send_range(1, 16);
    gap_pct = 0;
    drain_and_count("gaps", 4);
    check_got("gaps_w1", 1, mkwin('{2, 3, 4, 6, 7, 8, 10, 11, 12}, 1'b0));

    // Back-to-back frames.
    new_test();
    send_range(1, 16);
    send_range(101, 16);
    drain_and_count("b2b", 8);
    check_got("b2b_frame2_w0", 4, mkwin('{101, 102, 103, 105, 106, 107, 109, 110, 111}, 1'b0));

    // Reset mid-frame, then a fresh frame.
    new_test();
    send_range(1, 6);
    rst_n = 1'b0;
    sb.delete();
    m_col = 0;
    m_row = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_range(201, 16);
    drain_and_count("reset", 4);
    check_got("reset_w0", 0, mkwin('{201, 202, 203, 205, 206, 207, 209, 210, 211}, 1'b0));

    // Signed extremes at window corners.
    new_test();
    for (int i = 0; i < 16; i++) begin
      if (i == 0)       p = 9'h100;
      else if (i == 10) p = 9'h0FF;
      else              p = WIDTH'($urandom);
      send(p);
    end
    drain_and_count("signed", 4);
    checks++;
    if (got_q.size() == 0 || got_q[0].px[0 +: WIDTH] !== 9'h100 || got_q[0].px[8*WIDTH +: WIDTH] !== 9'h0FF) begin
      errors++;
      $display("FAIL signed_corners got=%h want_a0=100 a8=0ff", got_q.size() ? got_q[0].px : '0);
    end

    // Random frames with random gaps and downstream drops.
    new_test();
    gap_pct  = 30;
    drop_pct = 30;
    for (int i = 0; i < 3 * W * H; i++) send(WIDTH'($urandom));
    drain_and_count("random", 12);
    gap_pct  = 0;
    drop_pct = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
